// File: rtl/fetch_lane_reconfig_ctrl.sv
// Fetch lane reconfiguration sequencer.
// Drains fetch-2/decode, flushes, applies a new lane mask and settles.
module fetch_lane_reconfig_ctrl #(
  parameter int FETCH_WIDTH   = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int DRAIN_TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   reqValid_i,
  input  logic [FETCH_WIDTH-1:0] reqMask_i,
  output logic                   reqReady_o,
  input  logic                   drained_i,
  input  logic                   extFlush_i,
  output logic [FETCH_WIDTH-1:0] laneActive_o,
  output logic                   stall_o,
  output logic                   flush_o,
  output logic                   done_o,
  output logic                   timedOut_o
);

  localparam int TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [SW-1:0] SLOAD = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH,
    APPLY
  } state_t;

  state_t                 state_q;
  logic [FETCH_WIDTH-1:0] mask_q;
  logic [FETCH_WIDTH-1:0] lane_q;
  logic [TW-1:0]          tcnt_q;
  logic [SW-1:0]          scnt_q;
  logic                   tflag_q;
  logic                   stall_q;
  logic                   flush_q;
  logic                   done_q;
  logic                   tout_q;
  logic [FETCH_WIDTH-1:0] san_d;
  logic                   drainGo_d;
  logic                   tmo_d;

  // Smear the highest requested lane downward; lane 0 is always kept.
  always_comb begin
    san_d = '0;
    san_d[FETCH_WIDTH-1] = reqMask_i[FETCH_WIDTH-1];
    for (int i = FETCH_WIDTH - 2; i >= 0; i--) begin
      san_d[i] = reqMask_i[i] | san_d[i+1];
    end
    san_d[0] = 1'b1;
  end

  // Drain exit: real drain or back-end flush wins over the timeout.
  always_comb begin
    tmo_d     = (tcnt_q == TLAST);
    drainGo_d = drained_i | extFlush_i | tmo_d;
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '1;
      lane_q  <= '1;
      tcnt_q  <= '0;
      scnt_q  <= '0;
      tflag_q <= 1'b0;
      stall_q <= 1'b0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (reqValid_i) begin
            mask_q <= san_d;
            if (san_d == lane_q) begin
              done_q <= 1'b1;
            end else begin
              state_q <= DRAIN;
              stall_q <= 1'b1;
              tcnt_q  <= '0;
            end
          end
        end
        DRAIN: begin
          if (drainGo_d) begin
            state_q <= FLUSH;
            flush_q <= 1'b1;
            if (!drained_i && !extFlush_i) begin
              tflag_q <= 1'b1;
            end
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        FLUSH: begin
          state_q <= APPLY;
          lane_q  <= mask_q;
          scnt_q  <= SLOAD;
        end
        APPLY: begin
          if (scnt_q == '0) begin
            state_q <= IDLE;
            stall_q <= 1'b0;
            done_q  <= 1'b1;
            tout_q  <= tflag_q;
            tflag_q <= 1'b0;
          end else begin
            scnt_q <= scnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign reqReady_o   = (state_q == IDLE);
  assign laneActive_o = lane_q;
  assign stall_o      = stall_q;
  assign flush_o      = flush_q;
  assign done_o       = done_q;
  assign timedOut_o   = tout_q;

endmodule
